// File: rtl/id_ex_stage.sv
// ID/EX pipeline register, ALU-control decode, load-use bubble insertion and
// EX/MEM, MEM/WB operand forwarding. Forwarding muxes exist only when ID_EX_FORWARD_EN is defined.
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             flush,
  input  logic             idValid,
  input  logic [WIDTH-1:0] idRsData,
  input  logic [WIDTH-1:0] idRtData,
  input  logic [WIDTH-1:0] idImm,
  input  logic [RADDR-1:0] idRs,
  input  logic [RADDR-1:0] idRt,
  input  logic [RADDR-1:0] idRd,
  input  logic [1:0]       idAluOp,
  input  logic [5:0]       idFunct,
  input  logic [5:0]       idCtrl,
  input  logic             exMemRegWrite,
  input  logic [RADDR-1:0] exMemRd,
  input  logic [WIDTH-1:0] exMemResult,
  input  logic             memWbRegWrite,
  input  logic [RADDR-1:0] memWbRd,
  input  logic [WIDTH-1:0] memWbData,
  output logic [WIDTH-1:0] input1,
  output logic [WIDTH-1:0] input2,
  output logic [3:0]       aluCtrl,
  output logic [WIDTH-1:0] exStoreData,
  output logic [RADDR-1:0] exDestReg,
  output logic             exValid,
  output logic [3:0]       exCtrl,
  output logic             illegalOp,
  output logic             loadUseStall
);

  localparam int CTRL_ALUSRC  = 5;
  localparam int CTRL_REGDST  = 4;
  localparam int EXCTRL_MEMRD = 2;

  // Returns {illegal, aluCtrl[3:0]}; unknown R-type funct falls back to add.
  function automatic logic [4:0] alu_decode(input logic [1:0] op, input logic [5:0] funct);
    logic [4:0] res;
    res = {1'b0, 4'b0010};
    unique case (op)
      2'b00: res = {1'b0, 4'b0010};
      2'b01: res = {1'b0, 4'b0110};
      2'b11: res = {1'b0, 4'b0001};
      default: begin
        case (funct)
          6'b100000: res = {1'b0, 4'b0010};
          6'b100010: res = {1'b0, 4'b0110};
          6'b100100: res = {1'b0, 4'b0000};
          6'b100101: res = {1'b0, 4'b0001};
          6'b101010: res = {1'b0, 4'b0111};
          6'b100111: res = {1'b0, 4'b1100};
          default:   res = {1'b1, 4'b0010};
        endcase
      end
    endcase
    return res;
  endfunction

  logic             r_valid;
  logic             r_aluSrc;
  logic             r_illegal;
  logic [3:0]       r_aluCtrl;
  logic [3:0]       r_ctrl;
  logic [RADDR-1:0] r_rs;
  logic [RADDR-1:0] r_rt;
  logic [RADDR-1:0] r_destReg;
  logic [WIDTH-1:0] r_rsData;
  logic [WIDTH-1:0] r_rtData;
  logic [WIDTH-1:0] r_imm;

  logic [4:0]       w_dec;
  logic             w_loadUse;
  logic             w_bubble;
  logic [WIDTH-1:0] w_fwdRs;
  logic [WIDTH-1:0] w_fwdRt;

  assign w_dec = alu_decode(idAluOp, idFunct);

  assign w_loadUse = r_valid & r_ctrl[EXCTRL_MEMRD] & (r_destReg != '0) & idValid &
                     ((idRs == r_destReg) | (idRt == r_destReg));

  // Reset and flush beat hold; a stall or an empty slot only bubbles when not held.
  assign w_bubble = ~rst_n | flush | (~hold & (w_loadUse | ~idValid));

  // ---- ID -> EX register boundary ----
  always_ff @(posedge clk) begin
    if (w_bubble) begin
      r_valid   <= 1'b0;
      r_aluSrc  <= 1'b0;
      r_illegal <= 1'b0;
      r_aluCtrl <= '0;
      r_ctrl    <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_destReg <= '0;
      r_rsData  <= '0;
      r_rtData  <= '0;
      r_imm     <= '0;
    end else if (!hold) begin
      r_valid   <= 1'b1;
      r_aluSrc  <= idCtrl[CTRL_ALUSRC];
      r_illegal <= w_dec[4];
      r_aluCtrl <= w_dec[3:0];
      r_ctrl    <= idCtrl[3:0];
      r_rs      <= idRs;
      r_rt      <= idRt;
      r_destReg <= idCtrl[CTRL_REGDST] ? idRd : idRt;
      r_rsData  <= idRsData;
      r_rtData  <= idRtData;
      r_imm     <= idImm;
    end
  end

`ifdef ID_EX_FORWARD_EN
  // EX/MEM is the younger result, so it is tested first; r0 never forwards.
  function automatic logic [WIDTH-1:0] fwd_sel(
    input logic [RADDR-1:0] src,
    input logic [WIDTH-1:0] regVal,
    input logic             emWe,
    input logic [RADDR-1:0] emRd,
    input logic [WIDTH-1:0] emVal,
    input logic             mwWe,
    input logic [RADDR-1:0] mwRd,
    input logic [WIDTH-1:0] mwVal
  );
    if (emWe && (emRd != '0) && (emRd == src)) return emVal;
    if (mwWe && (mwRd != '0) && (mwRd == src)) return mwVal;
    return regVal;
  endfunction

  assign w_fwdRs = fwd_sel(r_rs, r_rsData, exMemRegWrite, exMemRd, exMemResult,
                           memWbRegWrite, memWbRd, memWbData);
  assign w_fwdRt = fwd_sel(r_rt, r_rtData, exMemRegWrite, exMemRd, exMemResult,
                           memWbRegWrite, memWbRd, memWbData);
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{exMemRegWrite, exMemRd, exMemResult,
                          memWbRegWrite, memWbRd, memWbData, r_rs, r_rt};
  assign w_fwdRs = r_rsData;
  assign w_fwdRt = r_rtData;
`endif

  assign input1       = w_fwdRs;
  assign input2       = r_aluSrc ? r_imm : w_fwdRt;
  assign exStoreData  = w_fwdRt;
  assign aluCtrl      = r_aluCtrl;
  assign exDestReg    = r_destReg;
  assign exValid      = r_valid;
  assign exCtrl       = r_ctrl;
  assign illegalOp    = r_illegal;
  assign loadUseStall = w_loadUse;

endmodule
